matrix_read_scheduler: RTL
==========================

MATRIX_READ_SCHEDULER -- requirements
Module: matrix_read_scheduler

Interface
REQ-001 Parameter layer_index_size, default 32, width of layer indices.
REQ-002 Parameter row_index_size, default 32, width of row indices and row counts.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_a_valid / req_b_valid  input  1  requester A/B burst request.
REQ-006 req_a_layer / req_b_layer  input  layer_index_size  layer to read.
REQ-007 req_a_row_count / req_b_row_count  input  row_index_size  rows to read, starting at row 0.
REQ-008 req_a_ready / req_b_ready  output  1  request accepted this cycle when ready and valid are both high.
REQ-009 rd_valid  output  1  read location valid.
REQ-010 rd_ready  input  1  downstream consumes the location.
REQ-011 read_layer_index  output  layer_index_size  layer of the current read.
REQ-012 read_row_index  output  row_index_size  row of the current read.
REQ-013 rd_owner  output  1  requester of the current read: 0 = A, 1 = B.
REQ-014 rd_last  output  1  current read is the final row of the burst.
REQ-015 busy  output  1  high in state ISSUE.
REQ-016 done_a / done_b  output  1  one-cycle burst-complete pulse.

Function
REQ-017 The FSM shall have exactly two states: IDLE and ISSUE.
REQ-018 In IDLE, the ready signals shall be combinational: req_x_ready = IDLE & req_x_valid & granted(x); at most one ready high per cycle.
REQ-019 Arbitration shall be round-robin.
- Sole valid requester wins.
- If both are valid, the requester not granted last wins.
- last_grant resets to B, so A wins the first tie.
REQ-020 On acceptance with row_count > 0, the scheduler shall:
- latch layer, row_count and owner;
- clear the row counter to 0;
- update last_grant;
- move to ISSUE, with rd_valid high the next cycle (one-cycle latency).
REQ-021 On acceptance with row_count = 0, the scheduler shall stay in IDLE, issue no read, update last_grant, and pulse done_x the next cycle.
REQ-022 In ISSUE, rd_valid shall be 1 and read_row_index shall equal the row counter.
REQ-023 While rd_valid is high and rd_ready is low, read_layer_index, read_row_index, rd_owner and rd_last shall hold stable.
REQ-024 Each cycle with rd_valid and rd_ready both high shall increment the row counter by 1.
REQ-025 rd_last shall be 1 when row counter = latched row_count - 1.
REQ-026 The handshake on rd_last shall return the FSM to IDLE and pulse done_owner for one cycle in the following cycle.
REQ-027 A new request may be accepted in the same cycle as a done pulse.
REQ-028 Counter comparison shall use the full row_index_size width; row_count = 2^row_index_size - 1 shall be legal and shall never wrap.
REQ-029 In IDLE, rd_valid shall be 0 and the index outputs shall hold their last values.
REQ-030 Changes to request inputs during ISSUE shall not affect the burst in flight.

Reset
REQ-031 Asserting rst_n low shall immediately force the following, including mid-burst; the aborted burst produces no done pulse:
- state = IDLE, last_grant = B;
- rd_valid, rd_last, busy, done_a, done_b = 0;
- read_layer_index, read_row_index, rd_owner and the row counter = 0.
REQ-032 Releasing rst_n shall allow request acceptance on the first clock edge after release.

Configuration
REQ-033 When macro MATRIX_READ_SCHEDULER_ABORT_EN is defined, an input port abort (1 bit) shall exist.
- abort high in ISSUE forces IDLE next cycle, rd_valid low, and a done_owner pulse.
- A read handshake in the abort cycle counts as completed.
- abort in IDLE is ignored.
REQ-034 Without MATRIX_READ_SCHEDULER_ABORT_EN, the abort port shall be absent and bursts run only to completion or reset.

Verification
REQ-035 Single burst: A valid, layer=5, count=3, rd_ready=1 -> rows 0,1,2 on consecutive cycles, layer 5, rd_owner=0, rd_last on row 2, done_a one cycle later.
REQ-036 Tie after reset: A and B both valid with count=2 -> A served first, B accepted in A's done cycle; a second tie goes to A (last grant was B).
REQ-037 Backpressure: count=4, rd_ready low for 3 cycles on row 1 -> row 1 and rd_last=0 held stable, then rows 2,3 issue; exactly 4 handshakes.
REQ-038 Zero count: B valid, count=0 -> req_b_ready=1, no rd_valid, done_b pulses next cycle, state stays IDLE.
REQ-039 Mid-burst reset: rst_n low during row 2 of 8 -> outputs zero immediately, no done pulse; after release, A wins the next tie.
REQ-040 With MATRIX_READ_SCHEDULER_ABORT_EN: abort during row 1 of 5 -> rd_valid low next cycle, done pulse for the owner, next request accepted normally.

Source files
------------

// File: rtl/matrix_read_scheduler.sv
// Round-robin burst read scheduler: two requesters, one row-by-row read stream.
// Optional abort input is compiled in with MATRIX_READ_SCHEDULER_ABORT_EN.
module matrix_read_scheduler #(
  parameter int layer_index_size = 32,
  parameter int row_index_size   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef MATRIX_READ_SCHEDULER_ABORT_EN
  input  logic                        abort,
`endif
  input  logic                        req_a_valid,
  input  logic [layer_index_size-1:0] req_a_layer,
  input  logic [row_index_size-1:0]   req_a_row_count,
  output logic                        req_a_ready,
  input  logic                        req_b_valid,
  input  logic [layer_index_size-1:0] req_b_layer,
  input  logic [row_index_size-1:0]   req_b_row_count,
  output logic                        req_b_ready,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [layer_index_size-1:0] read_layer_index,
  output logic [row_index_size-1:0]   read_row_index,
  output logic                        rd_owner,
  output logic                        rd_last,
  output logic                        busy,
  output logic                        done_a,
  output logic                        done_b
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  localparam logic [row_index_size-1:0]   ROW_ZERO   = {row_index_size{1'b0}};
  localparam logic [row_index_size-1:0]   ROW_ONE    = {{(row_index_size-1){1'b0}}, 1'b1};
  localparam logic [layer_index_size-1:0] LAYER_ZERO = {layer_index_size{1'b0}};

  logic [0:0]                  r_state;
  logic                        r_last_grant;
  logic [layer_index_size-1:0] r_layer;
  logic [row_index_size-1:0]   r_row;
  logic [row_index_size-1:0]   r_count;
  logic                        r_owner;
  logic                        r_done_a;
  logic                        r_done_b;

  logic                        w_idle;
  logic                        w_issue;
  logic                        w_grant_a;
  logic                        w_grant_b;
  logic                        w_accept;
  logic                        w_sel_b;
  logic [layer_index_size-1:0] w_sel_layer;
  logic [row_index_size-1:0]   w_sel_count;
  logic                        w_sel_zero;
  logic                        w_is_last;
  logic                        w_hs;
  logic                        w_abort;
  logic                        w_burst_end;
  logic [0:0]                  w_state_nxt;

  assign w_idle  = (r_state == IDLE);
  assign w_issue = (r_state == ISSUE);

  // last_grant = 1 means B was served last, so A wins a tie
  assign w_grant_a = req_a_valid & (~req_b_valid | r_last_grant);
  assign w_grant_b = req_b_valid & (~req_a_valid | ~r_last_grant);

  assign req_a_ready = w_idle & w_grant_a;
  assign req_b_ready = w_idle & w_grant_b;

  assign w_accept    = req_a_ready | req_b_ready;
  assign w_sel_b     = req_b_ready;
  assign w_sel_layer = w_sel_b ? req_b_layer : req_a_layer;
  assign w_sel_count = w_sel_b ? req_b_row_count : req_a_row_count;
  assign w_sel_zero  = (w_sel_count == ROW_ZERO);

  // r_count is never zero in ISSUE, so count-1 cannot underflow and row never wraps
  assign w_is_last = (r_row == (r_count - ROW_ONE));
  assign w_hs      = w_issue & rd_ready;

`ifdef MATRIX_READ_SCHEDULER_ABORT_EN
  assign w_abort = w_issue & abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_burst_end = (w_hs & w_is_last) | w_abort;

  // Next-state decode for the two-state controller
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_sel_zero) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (w_burst_end) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, burst context, row counter and done pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_layer      <= LAYER_ZERO;
      r_row        <= ROW_ZERO;
      r_count      <= ROW_ZERO;
      r_owner      <= 1'b0;
      r_done_a     <= 1'b0;
      r_done_b     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
      if (w_accept) begin
        r_last_grant <= w_sel_b;
        if (w_sel_zero) begin
          // empty burst completes immediately; read outputs keep their old values
          r_done_a <= ~w_sel_b;
          r_done_b <= w_sel_b;
        end else begin
          r_layer <= w_sel_layer;
          r_count <= w_sel_count;
          r_owner <= w_sel_b;
          r_row   <= ROW_ZERO;
        end
      end else if (w_burst_end) begin
        // row index is left on the final row so it holds through IDLE
        r_done_a <= ~r_owner;
        r_done_b <= r_owner;
      end else if (w_hs) begin
        r_row <= r_row + ROW_ONE;
      end
    end
  end

  assign rd_valid         = w_issue;
  assign busy             = w_issue;
  assign rd_last          = w_issue & w_is_last;
  assign read_layer_index = r_layer;
  assign read_row_index   = r_row;
  assign rd_owner         = r_owner;
  assign done_a           = r_done_a;
  assign done_b           = r_done_b;

endmodule
